// File: rtl/wt_dcache_vld_ctrl.sv
// wt_dcache_vld_ctrl: sequences the dcache tag/valid write port (init walk, flush walk)
// and arbitrates it between miss-unit refills and single-line invalidations.
module wt_dcache_vld_ctrl #(
  parameter int unsigned IdxWidth = 8,
  parameter int unsigned SetAssoc = 4,
  parameter int unsigned TagWidth = 44
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  input  logic                refill_vld_i,
  output logic                refill_rdy_o,
  input  logic [IdxWidth-1:0] refill_idx_i,
  input  logic [SetAssoc-1:0] refill_way_i,
  input  logic [TagWidth-1:0] refill_tag_i,
  input  logic                inv_vld_i,
  output logic                inv_rdy_o,
  input  logic [IdxWidth-1:0] inv_idx_i,
  input  logic [SetAssoc-1:0] inv_way_i,
  input  logic                inv_all_i,
  output logic                wr_cl_vld_o,
  output logic [SetAssoc-1:0] wr_cl_we_o,
  output logic [IdxWidth-1:0] wr_cl_idx_o,
  output logic [TagWidth-1:0] wr_cl_tag_o,
  output logic [SetAssoc-1:0] wr_vld_bits_o
);
  localparam logic [1:0] BOOT = 2'd0, INIT = 2'd1, IDLE = 2'd2, FLUSH = 2'd3;
  localparam logic [SetAssoc-1:0] ALL_WAYS = {SetAssoc{1'b1}};
  logic [1:0]          state_q, state_d;
  logic [IdxWidth-1:0] cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                walk, idle, last, flush_go, inv_wr;
  assign walk = (state_q == INIT) || (state_q == FLUSH);
  assign idle = state_q == IDLE;
  assign last = cnt_q == {IdxWidth{1'b1}};
  // A request still high during the ack cycle must not retrigger a flush.
  assign flush_go = idle & flush_req_i & ~ack_q;
  assign flush_ack_o = ack_q;
  assign busy_o = ~idle;
  assign refill_rdy_o = idle & ~flush_go & refill_vld_i;
  // During a walk invalidations are acked and dropped: every set gets cleared anyway.
  assign inv_rdy_o = inv_vld_i & (walk | (idle & ~flush_go & ~refill_vld_i));
  assign inv_wr = idle & inv_rdy_o;
  assign wr_cl_vld_o = walk | refill_rdy_o | inv_wr;
  assign wr_cl_we_o = walk ? ALL_WAYS : refill_rdy_o ? refill_way_i :
                      inv_wr ? (inv_all_i ? ALL_WAYS : inv_way_i) : '0;
  assign wr_cl_idx_o = walk ? cnt_q : refill_rdy_o ? refill_idx_i : inv_wr ? inv_idx_i : '0;
  assign wr_cl_tag_o = refill_rdy_o ? refill_tag_i : '0;
  assign wr_vld_bits_o = refill_rdy_o ? refill_way_i : '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    if (state_q == BOOT) state_d = INIT;
    else if (walk) begin
      cnt_d = cnt_q + IdxWidth'(1);
      if (last) begin
        state_d = IDLE;
        ack_d   = state_q == FLUSH;
      end
    end else if (flush_go) state_d = FLUSH;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end
endmodule
